// File: rtl/arb8_pkg.sv
// Shared types and constants for the eight-way grant arbiter.
// Holds the FSM encoding, requester/id sizes and a one-hot helper.
package arb8_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] id2onehot(
    input logic [ID_W-1:0] id
  );
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id == ID_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/arb8_grant_ctrl_enc.sv
// Priority encoder 8-to-3: highest set bit of d wins.
// Ports: d (request bits), y (winning index), valid (any bit set).
module priority_encoder_8to3
  import arb8_pkg::*;
(
  input  logic [N_REQ-1:0] d,
  output logic [ID_W-1:0]  y,
  output logic             valid
);

  always_comb begin
    y = '0;
    valid = |d;
    for (int i = 0; i < N_REQ; i++) begin
      if (d[i]) y = ID_W'(i);
    end
  end

endmodule

// File: rtl/arb8_grant_ctrl.sv
// Eight-requester grant controller: IDLE -> GRANT -> RECOVER.
// Ports: clk, rst (async high), req[7:0], done in;
//   gnt[7:0] one-hot, gnt_id, gnt_valid, timeout out.
// Grants end on done, own-request drop, or MAX_HOLD cycles.
// Define ARB8_ROUND_ROBIN_EN for rotating priority.
module arb8_grant_ctrl
  import arb8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  localparam int CNT_W = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;

  logic [N_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]  id_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;

  logic [N_REQ-1:0] enc_in;
  logic [ID_W-1:0]  enc_y;
  logic             enc_valid;
  logic [ID_W-1:0]  win_id;

  logic hold_limit;
  logic own_req;
  logic release_now;

`ifdef ARB8_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] src;

  // Rotate so that req[ptr] lands on bit 7 (top priority)
  always_comb begin
    enc_in = '0;
    src = '0;
    for (int j = 0; j < N_REQ; j++) begin
      src = ID_W'(j) + ptr + ID_W'(1);
      enc_in[j] = req[src];
    end
  end

  // Undo the rotation (mod 8 via 3-bit wrap)
  assign win_id = enc_y + ptr + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= ID_W'(N_REQ - 1);
    end else begin
      ptr <= ptr_nxt;
    end
  end
`else
  assign enc_in = req;
  assign win_id = enc_y;
`endif

  priority_encoder_8to3 u_enc (
    .d     (enc_in),
    .y     (enc_y),
    .valid (enc_valid)
  );

  assign hold_limit  = hold_cnt == CNT_W'(MAX_HOLD - 1);
  assign own_req     = req[gnt_id];
  assign release_now = done | ~own_req | hold_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt;
    id_nxt       = gnt_id;
    valid_nxt    = gnt_valid;
    timeout_nxt  = 1'b0;
`ifdef ARB8_ROUND_ROBIN_EN
    ptr_nxt      = ptr;
`endif
    unique case (state)
      ST_IDLE: begin
        if (enc_valid) begin
          state_nxt    = ST_GRANT;
          hold_cnt_nxt = '0;
          gnt_nxt      = id2onehot(win_id);
          id_nxt       = win_id;
          valid_nxt    = 1'b1;
`ifdef ARB8_ROUND_ROBIN_EN
          ptr_nxt      = win_id - ID_W'(1);
`endif
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_nxt = ST_RECOVER;
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          // Forced only when nothing else ended it
          timeout_nxt = hold_limit & ~done & own_req;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/arb8_grant_ctrl.md
# arb8_grant_ctrl

Eight-requester arbiter and grant controller for one shared resource. It sequences access through the `priority_encoder_8to3` datapath and holds one grant at a time. A grant ends on requester `done`, on request withdrawal, or on a hold-time limit. Priority is fixed (highest index wins) or rotating (round-robin), selected at compile time.

## Interface
Parameters:
- `MAX_HOLD`, 16, maximum consecutive cycles one grant may be held; legal range 2..256.
- `CNT_W`, `$clog2(MAX_HOLD)`, hold-counter width; derived, not overridden.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: request vector; bit i is requester i.
- `done` input 1: the current grantee finished; sampled only in GRANT.
- `gnt` output 8: one-hot grant; all zero when no grant is active.
- `gnt_id` output 3: index of the current grantee; valid when `gnt_valid` is high.
- `gnt_valid` output 1: a grant is active.
- `timeout` output 1: one-cycle pulse after a forced release at `MAX_HOLD`.

## Operation
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0, state=IDLE, `hold_cnt`=0, `ptr`=7.
- States: IDLE, GRANT, RECOVER.
- IDLE:
  - If `req` is nonzero, the arbiter encodes the winner and registers `gnt`, `gnt_id` and `gnt_valid`=1, then moves to GRANT with `hold_cnt`=0.
  - If `req` is zero, it stays in IDLE.
- GRANT:
  - Outputs stay stable.
  - `hold_cnt` increments once per cycle.
  - The block releases the grant when any of these is true:
    - `done`=1;
    - `req[gnt_id]`=0;
    - `hold_cnt`==`MAX_HOLD`-1.
  - On release, the block goes to RECOVER and clears `gnt`/`gnt_valid` on the same edge.
  - `gnt_id` holds its last value.
- RECOVER:
  - This is one mandatory idle cycle; `gnt_valid`=0.
  - `timeout`=1 only if the release was forced by the hold limit.
  - The block always returns to IDLE next.
- Simultaneous events: if `done` or a `req` drop coincides with the hold limit, the release is normal and `timeout` stays 0.
- Fixed priority: the highest set index wins (`req[7]` highest), as produced by the encoder.
- Rotating priority: see Configuration.
- `req` changes during GRANT do not affect the grant, except withdrawal of the grantee's own bit.
- Reset mid-grant: outputs clear immediately (asynchronously) and the state returns to IDLE. No `timeout` pulse is produced.

## Timing
- Grant latency: `req` is sampled in IDLE at edge t, and `gnt_valid` is high after edge t (visible in cycle t+1).
- Release: `done` is sampled at edge t, and `gnt_valid` is low in cycle t+1 (RECOVER).
- Back-to-back grants: the next grant is visible in cycle t+3 at the earliest, so there are 2 dead cycles between grants.
- Maximum hold: `gnt_valid` is high for exactly `MAX_HOLD` cycles before a forced release.
- `timeout` is high for exactly one cycle and coincides with RECOVER.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `ARB8_ROUND_ROBIN_EN`.
- Defined:
  - A 3-bit register `ptr` gives the highest-priority index.
  - Search order is `ptr`, `ptr`-1, …, `ptr`+1 (mod 8).
  - Implementation: rotate `req` so that bit `ptr` maps to bit 7, encode, then map the result back to the absolute index (mod 8).
  - On every grant to index k, `ptr` <= k-1 mod 8 (k=0 wraps to 7).
- Undefined:
  - Fixed priority is used and `ptr` logic is absent.
  - Port list and timing are identical in both builds.

## Structure
- Shared package `arb8_pkg` holds:
  - the state encoding (`ST_IDLE`=0, `ST_GRANT`=1, `ST_RECOVER`=2, 2 bits);
  - the requester count 8;
  - the id width 3;
  - the default `MAX_HOLD`.
- One sub-module is instantiated: `priority_encoder_8to3` (`d`, `y`, `valid`).
  - It is fed the rotated or raw `req`.
  - Its `valid` output gates the IDLE-to-GRANT transition.
- The rotator and the one-hot decode of `gnt` are inline in the controller.

## Test plan
- Reset: assert `rst` with `req`=8'hFF while in GRANT → in the same cycle `gnt`=0, `gnt_valid`=0, `timeout`=0; after deassertion the first grant goes to id 7.
- Fixed priority (macro off):
  - Drive `req`=8'b0010_0110 → one cycle later `gnt`=8'b0010_0000, `gnt_id`=5.
  - Pulse `done` → `gnt_valid` goes low for 2 cycles, then id 5 is granted again.
- Withdrawal: while id 5 is granted, clear `req[5]` (leaving `req`=8'b0000_0110) → release with `timeout`=0, then a grant to id 2 three cycles after the drop.
- Hold limit: with `MAX_HOLD`=4, hold `req`=8'h01 with no `done` → `gnt_valid` high for 4 cycles, `timeout`=1 for 1 cycle, then a regrant to id 0.
- Round-robin (macro on): hold `req`=8'hFF and pulse `done` in each grant's first cycle → grant ids 7, 6, 5, 4, 3, 2, 1, 0, 7.
- Done coincident with limit: with `MAX_HOLD`=4, assert `done` on the 4th grant cycle → normal release with `timeout`=0.
